// File: rtl/dft_pkg.sv
// dft_pkg
// Shared types and helpers for the DFT oscillator generator.
//   osc_state_t : frame controller states
//   OSC_LATENCY : cycles from an accepted sample to its W vector on the outputs
//   lut_value   : quarter-wave sine table entry, evaluated at elaboration
//   fold        : maps quadrant plus the two table reads onto (W_real, W_imag)
package dft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } osc_state_t;

  localparam int OSC_LATENCY = 2;

  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } osc_pair_t;

  // L[i] = round(A * sin(2*pi*(i+0.5)/(4N))), A = 2^(osc_w-1)-1.
  // The argument stays inside (0, pi/2), so a Taylor series that is truncated
  // well past double precision is exact enough and needs only basic real math.
  // Every entry is positive, so adding 0.5 before truncation rounds correctly.
  function automatic int lut_value(input int idx, input int addr_w, input int osc_w);
    real x;
    real x2;
    real term;
    real sum;
    real amp;
    x    = 2.0 * PI * (real'(idx) + 0.5) / real'(4 * (1 << addr_w));
    x2   = x * x;
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x2 / real'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = real'((1 << (osc_w - 1)) - 1);
    return $rtoi(amp * sum + 0.5);
  endfunction

  // l_a = L[a], l_b = L[N-1-a]. Result is (cos, -sin) of the full phase.
  function automatic osc_pair_t fold(input logic [1:0] q, input int l_a, input int l_b);
    osc_pair_t r;
    int s;
    int c;
    case (q)
      2'd0: begin s = l_a;  c = l_b;  end
      2'd1: begin s = l_b;  c = -l_a; end
      2'd2: begin s = -l_a; c = -l_b; end
      default: begin s = -l_b; c = l_a; end
    endcase
    r.re = c;
    r.im = -s;
    return r;
  endfunction

endpackage

// File: rtl/dft_osc_sincos_lut.sv
// dft_osc_sincos_lut
// Combinational quarter-wave sine ROM with two read ports. Port A reads L[a],
// port B reads the mirrored entry L[N-1-a]; together they cover sin and cos
// of one quadrant. Contents are computed at elaboration.
//   i_addr  : quarter-wave address a
//   o_lut_a : L[a]       (non-negative magnitude)
//   o_lut_b : L[N-1-a]   (non-negative magnitude)
module dft_osc_sincos_lut
  import dft_pkg::*;
#(
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int OSC_WIDTH      = 18
) (
  input  logic [LUT_ADDR_WIDTH-1:0] i_addr,
  output logic [OSC_WIDTH-1:0]      o_lut_a,
  output logic [OSC_WIDTH-1:0]      o_lut_b
);

  localparam int N = 1 << LUT_ADDR_WIDTH;

  logic [OSC_WIDTH-1:0] w_rom [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rom
    localparam int ENTRY = lut_value(gi, LUT_ADDR_WIDTH, OSC_WIDTH);
    assign w_rom[gi] = OSC_WIDTH'(ENTRY);
  end

  // N is a power of two, so N-1-a is the bitwise complement of a.
  assign o_lut_a = w_rom[i_addr];
  assign o_lut_b = w_rom[~i_addr];

endmodule

// File: rtl/dft_osc_generator.sv
// dft_osc_generator
// Produces W[n,k] = exp(-j*2*pi*f_k*n/fs) for NUM_BINS bins, one vector per
// accepted input sample, and frames each run with start/last/done pulses.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i              : frame request, honoured only in IDLE
//   num_samples_i        : frame length, latched on start
//   phase_inc_i[k]       : per-bin phase increment, latched on start
//   sample_valid_i       : one input sample this cycle (RUN only)
//   W_real_o/W_imag_o[k] : cos(phi_k) / -sin(phi_k), two cycles after the sample
//   w_valid_o, last_o    : W qualifier and final-sample tag
//   start_o, done_o      : one-cycle frame start / frame complete pulses
//   busy_o               : high in RUN and FLUSH
module dft_osc_generator
  import dft_pkg::*;
#(
  parameter int NUM_BINS           = 16,
  parameter int OSC_WIDTH          = 18,
  parameter int PHASE_WIDTH        = 24,
  parameter int LUT_ADDR_WIDTH     = 10,
  parameter int SAMPLE_COUNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [SAMPLE_COUNT_WIDTH-1:0] num_samples_i,
  input  logic [PHASE_WIDTH-1:0]        phase_inc_i [NUM_BINS],
  input  logic                          sample_valid_i,
  output logic signed [OSC_WIDTH-1:0]   W_real_o    [NUM_BINS],
  output logic signed [OSC_WIDTH-1:0]   W_imag_o    [NUM_BINS],
  output logic                          w_valid_o,
  output logic                          start_o,
  output logic                          last_o,
  output logic                          done_o,
  output logic                          busy_o
);

  osc_state_t                    r_state;
  logic [SAMPLE_COUNT_WIDTH-1:0] r_num_samples;
  logic [SAMPLE_COUNT_WIDTH-1:0] r_count;
  logic                          r_start;
  logic                          r_done;
  logic                          r_s1_valid;
  logic                          r_s1_last;
  logic                          r_w_valid;
  logic                          r_last;

  logic w_start_accept;
  logic w_sample_accept;
  logic w_last_accept;

  assign w_start_accept  = (r_state == IDLE) && start_i && (num_samples_i != '0);
  assign w_sample_accept = (r_state == RUN) && sample_valid_i;
  assign w_last_accept   = w_sample_accept &&
                           (r_count == r_num_samples - SAMPLE_COUNT_WIDTH'(1));

  // Frame controller.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_num_samples <= '0;
      r_count       <= '0;
      r_start       <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (num_samples_i != '0) begin
              r_num_samples <= num_samples_i;
              r_count       <= '0;
              r_start       <= 1'b1;
              r_state       <= RUN;
            end else begin
              // Empty frame: report completion without ever starting.
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (w_sample_accept) begin
            r_count <= r_count + SAMPLE_COUNT_WIDTH'(1);
            if (w_last_accept) begin
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Once stage 1 is empty the final W is in the output register this
          // cycle, so done lands exactly one cycle after last_o.
          if (!r_s1_valid) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Pipeline qualifiers shared by all bins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_w_valid  <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_s1_valid <= w_sample_accept;
      r_s1_last  <= w_last_accept;
      r_w_valid  <= r_s1_valid;
      r_last     <= r_s1_valid && r_s1_last;
    end
  end

  // Per-bin phase accumulator, address/fold stage and output register.
  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    logic [PHASE_WIDTH-1:0]         r_inc;
    logic [PHASE_WIDTH-1:0]         r_phase;
    logic [1:0]                     r_quad;
    logic [LUT_ADDR_WIDTH-1:0]      r_addr;
    logic signed [OSC_WIDTH-1:0]    r_w_real;
    logic signed [OSC_WIDTH-1:0]    r_w_imag;
    logic [OSC_WIDTH-1:0]           w_lut_a;
    logic [OSC_WIDTH-1:0]           w_lut_b;
    osc_pair_t                      w_pair;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_inc    <= '0;
        r_phase  <= '0;
        r_quad   <= '0;
        r_addr   <= '0;
        r_w_real <= '0;
        r_w_imag <= '0;
      end else begin
        if (w_start_accept) begin
          r_inc   <= phase_inc_i[gi];
          r_phase <= '0;
        end else if (w_sample_accept) begin
          r_phase <= r_phase + r_inc;
        end

        // Stage 1: the pre-increment phase is the one issued for this sample.
        // Phase LSBs below the table address are dropped without rounding.
        if (w_sample_accept) begin
          r_quad <= r_phase[PHASE_WIDTH-1 -: 2];
          r_addr <= r_phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
        end

        // Stage 2: outputs only move with a valid vector, otherwise they hold.
        if (r_s1_valid) begin
          r_w_real <= OSC_WIDTH'(w_pair.re);
          r_w_imag <= OSC_WIDTH'(w_pair.im);
        end
      end
    end

    dft_osc_sincos_lut #(
      .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH),
      .OSC_WIDTH     (OSC_WIDTH)
    ) u_lut (
      .i_addr (r_addr),
      .o_lut_a(w_lut_a),
      .o_lut_b(w_lut_b)
    );

    assign w_pair       = fold(r_quad, int'(w_lut_a), int'(w_lut_b));
    assign W_real_o[gi] = r_w_real;
    assign W_imag_o[gi] = r_w_imag;
  end

  assign w_valid_o = r_w_valid;
  assign last_o    = r_last;
  assign start_o   = r_start;
  assign done_o    = r_done;
  assign busy_o    = (r_state == RUN) || (r_state == FLUSH);

endmodule

// File: tb/tb_dft_osc_generator.sv
// tb_dft_osc_generator
// Directed stimulus against a scoreboard model: expected W for sample n of bin
// k is derived from phase = n*inc_k mod 2^PHASE_WIDTH, a sine table built with
// $sin, and trigonometric quadrant symmetry. One compare process checks every
// output each cycle.
module tb_dft_osc_generator;

  localparam int NB  = 16;
  localparam int OW  = 18;
  localparam int PW  = 24;
  localparam int LA  = 10;
  localparam int SW  = 16;
  localparam int NL  = 1 << LA;
  localparam int AMP = (1 << (OW - 1)) - 1;
  localparam real TB_PI = 3.14159265358979323846;
  localparam int BIG = 32'h7fff_ffff;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 start_i = 1'b0;
  logic [SW-1:0]        num_samples_i = '0;
  logic [PW-1:0]        tb_inc [NB];
  logic                 sample_valid_i = 1'b0;
  logic signed [OW-1:0] w_real [NB];
  logic signed [OW-1:0] w_imag [NB];
  logic                 w_valid_o;
  logic                 start_o;
  logic                 last_o;
  logic                 done_o;
  logic                 busy_o;

  dft_osc_generator #(
    .NUM_BINS          (NB),
    .OSC_WIDTH         (OW),
    .PHASE_WIDTH       (PW),
    .LUT_ADDR_WIDTH    (LA),
    .SAMPLE_COUNT_WIDTH(SW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .num_samples_i (num_samples_i),
    .phase_inc_i   (tb_inc),
    .sample_valid_i(sample_valid_i),
    .W_real_o      (w_real),
    .W_imag_o      (w_imag),
    .w_valid_o     (w_valid_o),
    .start_o       (start_o),
    .last_o        (last_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int lut [NL];

  typedef struct packed {
    int due;
    bit last;
    int n;
  } exp_t;
  exp_t sb[$];

  bit            m_running = 1'b0;
  int            m_n = 0;
  int            m_num = 0;
  logic [PW-1:0] m_inc [NB];
  int            m_start_due = -1;
  int            m_done_due = -1;
  int            m_busy_lo = 0;
  int            m_busy_hi = -1;
  int            m_idle_from = 0;

  function automatic void chk(input string name, input longint act, input longint want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
    end
  endfunction

  // (cos, -sin) of a phase word from the quarter-wave table and symmetry.
  function automatic void exp_w(input logic [PW-1:0] ph, output int re, output int im);
    logic [1:0] q;
    int a;
    int sm;
    int cm;
    q  = ph[PW-1 -: 2];
    a  = int'(ph[PW-3 -: LA]);
    sm = q[0] ? lut[NL-1-a] : lut[a];
    cm = q[0] ? lut[a] : lut[NL-1-a];
    re = (q == 2'd1 || q == 2'd2) ? -cm : cm;
    im = q[1] ? sm : -sm;
  endfunction

  // Drive one cycle of inputs and advance the model for that cycle.
  task automatic drive(input bit st, input int num, input bit v);
    @(posedge clk);
    #1;
    start_i        = st;
    num_samples_i  = SW'(num);
    sample_valid_i = v;
    if (v && m_running) begin
      sb.push_back('{due: cyc + 2, last: (m_n == m_num - 1), n: m_n});
      if (m_n == m_num - 1) begin
        m_running   = 1'b0;
        m_done_due  = cyc + 3;
        m_busy_hi   = cyc + 2;
        m_idle_from = cyc + 4;
      end
      m_n++;
    end
    if (st && !m_running && cyc >= m_idle_from) begin
      if (num != 0) begin
        m_running   = 1'b1;
        m_n         = 0;
        m_num       = num;
        m_start_due = cyc + 1;
        m_busy_lo   = cyc + 1;
        m_busy_hi   = BIG;
        m_idle_from = BIG;
        for (int k = 0; k < NB; k++) m_inc[k] = tb_inc[k];
      end else begin
        m_done_due  = cyc + 1;
        m_idle_from = cyc + 2;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_w_valid"}, w_valid_o, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    for (int k = 0; k < NB; k++) begin
      chk({tag, "_re"}, w_real[k], 0);
      chk({tag, "_im"}, w_imag[k], 0);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_ni         = 1'b0;
    start_i        = 1'b0;
    sample_valid_i = 1'b0;
    sb.delete();
    m_running   = 1'b0;
    m_start_due = -1;
    m_done_due  = -1;
    m_busy_hi   = -1;
    m_idle_from = 0;
    #1;
    check_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Compare process: every output, every cycle.
  always @(negedge clk) begin : cmp
    bit            ev;
    exp_t          it;
    int            re;
    int            im;
    int            bad;
    int            bad_re;
    int            bad_im;
    logic [63:0]   p;
    ev = (sb.size() != 0) && (sb[0].due == cyc);
    chk("w_valid", w_valid_o, ev);
    if (ev) begin
      it     = sb.pop_front();
      bad    = -1;
      bad_re = 0;
      bad_im = 0;
      chk("last", last_o, it.last);
      for (int k = 0; k < NB; k++) begin
        p = 64'(it.n) * 64'(m_inc[k]);
        exp_w(p[PW-1:0], re, im);
        if (bad < 0 && (int'(w_real[k]) != re || int'(w_imag[k]) != im)) begin
          bad    = k;
          bad_re = re;
          bad_im = im;
        end
      end
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL W sample %0d bin %0d at cycle %0d: got (%0d,%0d), expected (%0d,%0d)",
                 it.n, bad, cyc, w_real[bad], w_imag[bad], bad_re, bad_im);
      end else begin
        $display("cycle %0d sample %0d W0=(%0d,%0d) last=%0b ok",
                 cyc, it.n, w_real[0], w_imag[0], it.last);
      end
    end
    chk("start_o", start_o, cyc == m_start_due);
    chk("done_o", done_o, cyc == m_done_due);
    chk("busy_o", busy_o, rst_ni && cyc >= m_busy_lo && cyc <= m_busy_hi);
  end

  int gaps [5] = '{0, 2, 1, 3, 0};

  initial begin : main
    int re;
    int im;
    for (int i = 0; i < NL; i++) begin
      lut[i] = $rtoi(real'(AMP) * $sin(2.0 * TB_PI * (real'(i) + 0.5) / (4.0 * real'(NL))) + 0.5);
    end
    for (int k = 0; k < NB; k++) begin
      tb_inc[k] = '0;
      m_inc[k]  = '0;
    end

    // Pin the model against hand-computed table entries and quadrant values.
    chk("pin_lut0", lut[0], 101);
    chk("pin_lut_last", lut[NL-1], 131071);
    exp_w(24'h000000, re, im);
    chk("pin_q0_re", re, 131071);
    chk("pin_q0_im", im, -101);
    exp_w(24'h400000, re, im);
    chk("pin_q1_re", re, -101);
    chk("pin_q1_im", im, -131071);
    exp_w(24'h800000, re, im);
    chk("pin_q2_re", re, -131071);
    chk("pin_q2_im", im, 101);
    exp_w(24'hC00000, re, im);
    chk("pin_q3_re", re, 101);
    chk("pin_q3_im", im, 131071);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    repeat (4) drive(0, 0, 0);

    // DC frame, preceded by valids in IDLE that must be ignored.
    drive(0, 4, 1);
    drive(0, 4, 1);
    drive(1, 4, 0);
    repeat (4) drive(0, 4, 1);
    repeat (6) drive(0, 0, 0);

    // Bin k steps by k*2^20, so bin 4 runs at fs/4.
    for (int k = 0; k < NB; k++) tb_inc[k] = PW'(k << 20);
    drive(1, 4, 0);
    repeat (4) drive(0, 4, 1);
    repeat (6) drive(0, 0, 0);

    // Gapped valids with a start in RUN (ignored, new incs not latched),
    // valids in FLUSH/DONE, then an empty frame and a start in DONE.
    for (int k = 0; k < NB; k++) tb_inc[k] = PW'($urandom);
    drive(1, 5, 0);
    for (int i = 0; i < 5; i++) begin
      repeat (gaps[i]) drive(0, 5, 0);
      if (i == 2) begin
        for (int k = 0; k < NB; k++) tb_inc[k] = PW'($urandom);
        drive(1, 9, 1);
      end else begin
        drive(0, 5, 1);
      end
    end
    drive(0, 5, 1);
    drive(0, 5, 1);
    drive(0, 5, 1);
    drive(1, 0, 0);
    drive(1, 0, 0);
    repeat (4) drive(0, 0, 0);

    // Long frame with random increments, reset after 500 samples.
    for (int k = 0; k < NB; k++) tb_inc[k] = PW'($urandom);
    drive(1, 1024, 0);
    repeat (500) drive(0, 1024, 1);
    pulse_reset();
    repeat (8) drive(0, 0, 0);

    // Recovery after reset.
    drive(1, 2, 0);
    repeat (2) drive(0, 2, 1);
    repeat (6) drive(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
